// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
// Upstream stage for the 1101 Moore sequence detector. Accepts parallel
// words over a valid/ready handshake and serializes them one bit per clock
// onto the detector's serial input. Words can be sent back to back with no
// idle gap, so patterns that span word boundaries reach the detector intact.
//
// Parameters:
//   WIDTH     - data word width in bits (2..15)
//   MSB_FIRST - 1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//   CNT_W     - width of bit_cnt, 2**CNT_W must exceed WIDTH
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   load_valid - data_in holds a word to transmit
//   load_ready - feeder accepts a word this cycle (decoded from state)
//   data_in    - parallel word, sampled on accept
//   x          - serial bit stream to the detector
//   x_valid    - x carries a frame bit this cycle
//   busy       - frame in progress
//   bit_cnt    - index of the bit currently on x, 0 = first bit of frame
//
// Optional feature (macro SERIAL_FEEDER_PARITY_EN):
//   When defined, a PARITY state follows the last data bit and presents the
//   even-parity bit of the accepted word with bit_cnt = WIDTH. The reload
//   window then moves from the last data bit to the parity bit.

module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SERIAL_FEEDER_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [CNT_W-1:0] PAR_CNT = CNT_W'(WIDTH);
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH-1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             accept;
  logic             load_x;
  logic [WIDTH-1:0] load_sreg;
  logic             shift_x;
  logic [WIDTH-1:0] shift_sreg;

  // The first bit of a word goes straight into x_q on the accepting edge, so
  // the shift register only ever holds the bits still waiting to go out.
  always_comb begin
    if (MSB_FIRST) begin
      load_x     = data_in[WIDTH-1];
      load_sreg  = {data_in[WIDTH-2:0], 1'b0};
      shift_x    = sreg_q[WIDTH-1];
      shift_sreg = {sreg_q[WIDTH-2:0], 1'b0};
    end else begin
      load_x     = data_in[0];
      load_sreg  = {1'b0, data_in[WIDTH-1:1]};
      shift_x    = sreg_q[0];
      shift_sreg = {1'b0, sreg_q[WIDTH-1:1]};
    end
  end

  // Ready is a pure state decode so it reads 1 throughout reset (IDLE).
  always_comb begin
`ifdef SERIAL_FEEDER_PARITY_EN
    load_ready = (state_q == IDLE) || (state_q == PARITY);
`else
    load_ready = (state_q == IDLE) ||
                 ((state_q == SHIFT) && (bit_cnt_q == LAST_CNT));
`endif
    accept = load_valid && load_ready;
  end

  // Next-state logic. A reload on the final bit of a frame takes the same
  // path as a load from IDLE, which gives zero-gap back-to-back words.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    x_d       = x_q;
    x_valid_d = x_valid_q;
    bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_FEEDER_PARITY_EN
    parity_d  = parity_q;
`endif

    if (accept) begin
      state_d   = SHIFT;
      sreg_d    = load_sreg;
      x_d       = load_x;
      x_valid_d = 1'b1;
      bit_cnt_d = '0;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_d  = ^data_in;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (bit_cnt_q == LAST_CNT) begin
`ifdef SERIAL_FEEDER_PARITY_EN
            state_d   = PARITY;
            x_d       = parity_q;
            x_valid_d = 1'b1;
            bit_cnt_d = PAR_CNT;
`else
            state_d   = IDLE;
            sreg_d    = '0;
            x_d       = 1'b0;
            x_valid_d = 1'b0;
            bit_cnt_d = '0;
`endif
          end else begin
            sreg_d    = shift_sreg;
            x_d       = shift_x;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
`ifdef SERIAL_FEEDER_PARITY_EN
        PARITY: begin
          state_d   = IDLE;
          sreg_d    = '0;
          x_d       = 1'b0;
          x_valid_d = 1'b0;
          bit_cnt_d = '0;
        end
`endif
        default: begin
          state_d   = IDLE;
          x_d       = 1'b0;
          x_valid_d = 1'b0;
          bit_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      bit_cnt_q <= '0;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef SERIAL_FEEDER_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign bit_cnt = bit_cnt_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_serial_bit_feeder.sv
module tb_serial_bit_feeder;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;
`ifdef SERIAL_FEEDER_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif

   logic             clk;
   logic             rstN;
   logic             loadValid;
   logic [WIDTH-1:0] dataIn;

   logic             loadReady, x, xValid, busy;
   logic [CNT_W-1:0] bitCnt;
   logic             loadReadyLsb, xLsb, xValidLsb, busyLsb;
   logic [CNT_W-1:0] bitCntLsb;

   int checkCount;
   int errorCount;

   logic [WIDTH-1:0] modelWord;
   int               modelIdx;
   bit               modelActive;

   bit               collectOn;
   logic [3:0]       detectHist;
   int               detectCount;

   // MSB-first instance, the default configuration.
   serial_bit_feeder #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst_n(rstN),
      .load_valid(loadValid),
      .load_ready(loadReady),
      .data_in(dataIn),
      .x(x),
      .x_valid(xValid),
      .busy(busy),
      .bit_cnt(bitCnt)
   );

   // LSB-first instance sharing the same stimulus, so both bit orders are
   // held against the same reference frame.
   serial_bit_feeder #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .CNT_W(CNT_W)) dutLsb (
      .clk(clk),
      .rst_n(rstN),
      .load_valid(loadValid),
      .load_ready(loadReadyLsb),
      .data_in(dataIn),
      .x(xLsb),
      .x_valid(xValidLsb),
      .busy(busyLsb),
      .bit_cnt(bitCntLsb)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single point of comparison: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Bit k of a frame as defined by the word and the bit order; past the
   // data bits comes the even-parity bit of the whole word.
   function automatic int expBit(input logic [WIDTH-1:0] word, input int k, input bit msbFirst);
      if (k >= WIDTH) return int'(^word);
      if (msbFirst) return int'(word[WIDTH-1-k]);
      return int'(word[k]);
   endfunction

   // Reference view of the outputs: a frame is a list of FRAME bits and the
   // model simply tracks which position of which word is on the wire.
   task automatic checkAll();
      bit readyExp;
      readyExp = !modelActive || (modelIdx == FRAME - 1);
      checkOutput("x",          int'(x),          modelActive ? expBit(modelWord, modelIdx, 1'b1) : 0);
      checkOutput("x_lsb",      int'(xLsb),       modelActive ? expBit(modelWord, modelIdx, 1'b0) : 0);
      checkOutput("x_valid",    int'(xValid),     int'(modelActive));
      checkOutput("x_valid_lsb",int'(xValidLsb),  int'(modelActive));
      checkOutput("busy",       int'(busy),       int'(modelActive));
      checkOutput("busy_lsb",   int'(busyLsb),    int'(modelActive));
      checkOutput("bit_cnt",    int'(bitCnt),     modelActive ? modelIdx : 0);
      checkOutput("bit_cnt_lsb",int'(bitCntLsb),  modelActive ? modelIdx : 0);
      checkOutput("load_ready", int'(loadReady),  int'(readyExp));
      checkOutput("load_ready_lsb", int'(loadReadyLsb), int'(readyExp));
   endtask

   // One clock of stimulus: check what is on the wire at the falling edge,
   // feed the MSB-first stream to a small 1101 counter when enabled, then
   // drive the inputs for the next rising edge and advance the model.
   task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data);
      bit readyExp;
      @(negedge clk);
      checkAll();
      if (collectOn && xValid) begin
         detectHist = {detectHist[2:0], x};
         if (detectHist == 4'b1101) detectCount++;
      end
      loadValid = valid;
      dataIn    = data;
      readyExp  = !modelActive || (modelIdx == FRAME - 1);
      if (valid && readyExp) begin
         modelWord   = data;
         modelIdx    = 0;
         modelActive = 1'b1;
      end else if (modelActive) begin
         modelIdx++;
         if (modelIdx == FRAME) begin
            modelActive = 1'b0;
            modelIdx    = 0;
         end
      end
   endtask

   // Sends one word and lets the frame drain completely.
   task automatic sendWord(input logic [WIDTH-1:0] data);
      applyStimulus(1'b1, data);
      for (int i = 0; i < FRAME + 1; i++) applyStimulus(1'b0, '0);
   endtask

   // Pulls reset between clock edges and checks that the outputs collapse
   // without waiting for an edge, then releases it before the next edge.
   task automatic midFrameReset();
      @(negedge clk);
      checkAll();
      rstN      = 1'b0;
      loadValid = 1'b0;
      #1;
      checkOutput("rst_x",          int'(x),          0);
      checkOutput("rst_x_valid",    int'(xValid),     0);
      checkOutput("rst_busy",       int'(busy),       0);
      checkOutput("rst_bit_cnt",    int'(bitCnt),     0);
      checkOutput("rst_load_ready", int'(loadReady),  1);
      checkOutput("rst_x_lsb",      int'(xLsb),       0);
      #1;
      rstN        = 1'b1;
      modelActive = 1'b0;
      modelIdx    = 0;
   endtask

   // Directed scenarios from the test plan followed by randomized traffic.
   initial begin
      checkCount  = 0;
      errorCount  = 0;
      modelWord   = '0;
      modelIdx    = 0;
      modelActive = 1'b0;
      collectOn   = 1'b0;
      detectHist  = '0;
      detectCount = 0;
      rstN        = 1'b0;
      loadValid   = 1'b0;
      dataIn      = '0;

      #2;
      checkAll();
      @(negedge clk);
      checkAll();
      rstN = 1'b1;

      sendWord(8'b1101_1010);

      collectOn = 1'b1;
      applyStimulus(1'b1, 8'hD0);
      for (int i = 0; i < FRAME; i++) applyStimulus(1'b1, 8'h0D);
      for (int i = 0; i < FRAME + 2; i++) applyStimulus(1'b0, '0);
      collectOn = 1'b0;
      checkOutput("detect_1101", detectCount, 2);

      sendWord(8'h0B);

      applyStimulus(1'b1, 8'h00);
      applyStimulus(1'b0, 8'h00);
      applyStimulus(1'b0, 8'h00);
      applyStimulus(1'b1, 8'hFF);
      for (int i = 0; i < FRAME; i++) applyStimulus(1'b0, '0);

      applyStimulus(1'b1, 8'hA5);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0);
      midFrameReset();
      sendWord(8'h3C);

      sendWord(8'b1101_0001);
      sendWord(8'h01);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 3) != 0), WIDTH'($urandom));
      end
      for (int i = 0; i < FRAME + 2; i++) applyStimulus(1'b0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
